// File: rtl/nv_nvdla_pdp_unpack_pkg.sv
// Shared definitions for the PDP RDMA unpack stage: sideband bit positions,
// control FSM states and the flag bundle handed to the pooling pre-stage.
package nv_nvdla_pdp_unpack_pkg;

    // Bit positions inside the 14-bit RDMA sideband; bits [13:8] are reserved.
    localparam int unsigned SB_LINE_END  = 0;
    localparam int unsigned SB_SURF_END  = 1;
    localparam int unsigned SB_SPLIT_END = 2;
    localparam int unsigned SB_CUBE_END  = 3;
    localparam int unsigned SB_POS_C_LSB = 4;
    localparam int unsigned SB_WIDTH     = 14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } unpk_state_e;

    // Packed so that it maps directly onto unpk2pool_flags[3:0].
    typedef struct packed {
        logic cube_end;
        logic surf_end;
        logic line_end;
        logic first_of_surf;
    } unpk_flags_t;

endpackage

// File: rtl/nv_nvdla_pdp_unpack_skid.sv
// Generic 2-entry skid buffer. Output always comes from the head entry, and
// the input ready is a flop computed from next-cycle occupancy, so there is
// no combinational path from out_ready back to in_ready.
module nv_nvdla_pdp_unpack_skid #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_allow,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [1:0]       occ_q, occ_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic             ready_q;
    logic             push, pop;

    assign push      = in_valid && ready_q;
    assign pop       = out_valid && out_ready;
    assign out_valid = (occ_q != 2'd0);
    assign out_data  = head_q;
    assign in_ready  = ready_q;

    // Next occupancy and entry contents; a push while full cannot occur
    // because ready is low whenever occupancy is 2.
    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        case (occ_q)
            2'd0: begin
                if (push) begin
                    head_d = in_data;
                    occ_d  = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_d = in_data;
                end else if (push) begin
                    tail_d = in_data;
                    occ_d  = 2'd2;
                end else if (pop) begin
                    occ_d  = 2'd0;
                end
            end
            2'd2: begin
                if (pop) begin
                    head_d = tail_q;
                    occ_d  = 2'd1;
                end
            end
            default: occ_d = 2'd0;
        endcase
    end

    // Storage, occupancy and registered ready.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            occ_q   <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            occ_q   <= occ_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            ready_q <= in_allow && (occ_d != 2'd2);
        end
    end

endmodule

// File: rtl/nv_nvdla_pdp_rdma_unpack.sv
// PDP RDMA unpack stage (off-fly). Skid-buffers the RDMA stream, tracks the
// w/h/surface position of each beat, forwards locally computed position
// flags with the data and flags a sticky error when the RDMA end flags
// disagree. Define NVDLA_PDP_UNPACK_PERF_EN to add the unpk_perf_stall
// output counting downstream back-pressure cycles.
module nv_nvdla_pdp_rdma_unpack
    import nv_nvdla_pdp_unpack_pkg::*;
#(
    parameter int unsigned BWPE       = 8,
    parameter int unsigned THROUGHPUT = 8,
    localparam int unsigned DW        = BWPE * THROUGHPUT
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rstn,
    input  logic             reg2dp_op_en,
    input  logic [12:0]      reg2dp_cube_in_width,
    input  logic [12:0]      reg2dp_cube_in_height,
    input  logic [12:0]      reg2dp_cube_in_channel,
    input  logic             rdma2unpk_valid,
    output logic             rdma2unpk_ready,
    input  logic [DW+13:0]   rdma2unpk_pd,
    output logic             unpk2pool_valid,
    input  logic             unpk2pool_ready,
    output logic [DW-1:0]    unpk2pool_data,
    output logic [3:0]       unpk2pool_flags,
    output logic             unpk2pool_done,
    output logic             unpk_err
`ifdef NVDLA_PDP_UNPACK_PERF_EN
    ,
    output logic [31:0]      unpk_perf_stall
`endif
);

    localparam int unsigned SKID_W = DW + 4;
    localparam logic [12:0] TP     = 13'(THROUGHPUT);

    unpk_state_e state_q, state_d;
    logic        op_en_q;
    logic        op_start;
    logic [12:0] w_cnt_q, w_cnt_d;
    logic [12:0] h_cnt_q, h_cnt_d;
    logic [9:0]  s_cnt_q, s_cnt_d;
    logic        err_q, err_d;
    logic        done;
    logic        up_accept;
    logic        last_surf;
    logic [12:0] surf_last;
    logic [SB_WIDTH-1:0] sb;
    unpk_flags_t flags_c;
    logic        flag_mismatch;
    logic [SKID_W-1:0] skid_in, skid_out;
    logic        skid_valid;
    logic        unused_sb;

    assign sb        = rdma2unpk_pd[DW +: SB_WIDTH];
    assign unused_sb = ^{sb[SB_WIDTH-1:SB_POS_C_LSB], sb[SB_SPLIT_END]};
    assign op_start  = reg2dp_op_en && !op_en_q;
    assign up_accept = rdma2unpk_valid && rdma2unpk_ready;

    // Index of the last channel atom (surface): ceil((channel+1)/THROUGHPUT)-1.
    assign surf_last = reg2dp_cube_in_channel / TP;
    assign last_surf = ({3'b000, s_cnt_q} == surf_last);

    // Position flags for the beat currently offered upstream.
    always_comb begin
        flags_c.line_end      = (w_cnt_q == reg2dp_cube_in_width);
        flags_c.surf_end      = flags_c.line_end && (h_cnt_q == reg2dp_cube_in_height);
        flags_c.cube_end      = flags_c.surf_end && last_surf;
        flags_c.first_of_surf = (w_cnt_q == 13'd0) && (h_cnt_q == 13'd0);
    end

    assign flag_mismatch = (sb[SB_LINE_END] != flags_c.line_end) ||
                           (sb[SB_SURF_END] != flags_c.surf_end) ||
                           (sb[SB_CUBE_END] != flags_c.cube_end);

    // FSM next state, position counters and error capture.
    always_comb begin
        state_d = state_q;
        w_cnt_d = w_cnt_q;
        h_cnt_d = h_cnt_q;
        s_cnt_d = s_cnt_q;
        err_d   = err_q;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (op_start) begin
                    state_d = RUN;
                    w_cnt_d = '0;
                    h_cnt_d = '0;
                    s_cnt_d = '0;
                    err_d   = 1'b0;
                end
            end
            RUN: begin
                if (up_accept) begin
                    if (flags_c.line_end) begin
                        w_cnt_d = '0;
                        if (flags_c.surf_end) begin
                            h_cnt_d = '0;
                            s_cnt_d = flags_c.cube_end ? 10'd0 : s_cnt_q + 10'd1;
                        end else begin
                            h_cnt_d = h_cnt_q + 13'd1;
                        end
                    end else begin
                        w_cnt_d = w_cnt_q + 13'd1;
                    end
                    if (flag_mismatch) begin
                        err_d = 1'b1;
                    end
                    if (flags_c.cube_end) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Empty skid means the cube_end beat has left downstream.
                if (!skid_valid) begin
                    state_d = IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state registers.
    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            state_q <= IDLE;
            op_en_q <= 1'b0;
            w_cnt_q <= '0;
            h_cnt_q <= '0;
            s_cnt_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_en_q <= reg2dp_op_en;
            w_cnt_q <= w_cnt_d;
            h_cnt_q <= h_cnt_d;
            s_cnt_q <= s_cnt_d;
            err_q   <= err_d;
        end
    end

    assign skid_in = {flags_c, rdma2unpk_pd[DW-1:0]};

    nv_nvdla_pdp_unpack_skid #(
        .WIDTH (SKID_W)
    ) u_skid (
        .clk       (nvdla_core_clk),
        .rstn      (nvdla_core_rstn),
        .in_allow  (state_d == RUN),
        .in_valid  (rdma2unpk_valid),
        .in_ready  (rdma2unpk_ready),
        .in_data   (skid_in),
        .out_valid (skid_valid),
        .out_ready (unpk2pool_ready),
        .out_data  (skid_out)
    );

    assign unpk2pool_valid = skid_valid;
    assign unpk2pool_data  = skid_out[DW-1:0];
    assign unpk2pool_flags = skid_out[DW +: 4];
    assign unpk2pool_done  = done;
    assign unpk_err        = err_q;

`ifdef NVDLA_PDP_UNPACK_PERF_EN
    logic [31:0] perf_q;

    // Saturating count of active cycles where downstream holds off valid data.
    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            perf_q <= '0;
        end else if (state_q == IDLE && op_start) begin
            perf_q <= '0;
        end else if (state_q != IDLE && skid_valid && !unpk2pool_ready && perf_q != '1) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign unpk_perf_stall = perf_q;
`endif

endmodule

// File: tb/tb_nv_nvdla_pdp_rdma_unpack.sv
// Self-checking bench for nv_nvdla_pdp_rdma_unpack: randomized data and
// back-pressure, expected beats queued at upstream accept and checked by an
// independent output monitor.
module tb_nv_nvdla_pdp_rdma_unpack;

    localparam int BWPE       = 8;
    localparam int THROUGHPUT = 8;
    localparam int DW         = BWPE * THROUGHPUT;
    localparam int CW         = DW + 4;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           op_en = 1'b0;
    logic [12:0]    cw = '0, ch = '0, cc = '0;
    logic           up_valid = 1'b0;
    logic           up_ready;
    logic [DW+13:0] up_pd = '0;
    logic           dn_valid;
    logic           dn_ready = 1'b0;
    logic [DW-1:0]  dn_data;
    logic [3:0]     dn_flags;
    logic           done;
    logic           err;

    always #5 clk = ~clk;

    nv_nvdla_pdp_rdma_unpack #(
        .BWPE       (BWPE),
        .THROUGHPUT (THROUGHPUT)
    ) dut (
        .nvdla_core_clk         (clk),
        .nvdla_core_rstn        (rstn),
        .reg2dp_op_en           (op_en),
        .reg2dp_cube_in_width   (cw),
        .reg2dp_cube_in_height  (ch),
        .reg2dp_cube_in_channel (cc),
        .rdma2unpk_valid        (up_valid),
        .rdma2unpk_ready        (up_ready),
        .rdma2unpk_pd           (up_pd),
        .unpk2pool_valid        (dn_valid),
        .unpk2pool_ready        (dn_ready),
        .unpk2pool_data         (dn_data),
        .unpk2pool_flags        (dn_flags),
        .unpk2pool_done         (done),
        .unpk_err               (err)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [CW-1:0] exp_q[$];
    int cyc = 0;
    int occ_m = 0;
    int done_due = -1;
    int done_cnt = 0;
    int first_pop = -1;
    int last_pop = -1;
    int rmode = 0;

    task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Flags of beat k from cube geometry: beats walk w fastest, then h, then surface.
    function automatic logic [3:0] model_flags(input int k, input int w, input int h, input int c);
        int  wp, hp, sp, ns;
        logic le, se, ce, fs;
        wp = k % (w + 1);
        hp = (k / (w + 1)) % (h + 1);
        sp = k / ((w + 1) * (h + 1));
        ns = c / THROUGHPUT + 1;
        le = (wp == w);
        se = le && (hp == h);
        ce = se && (sp == ns - 1);
        fs = (wp == 0) && (hp == 0);
        return {ce, se, le, fs};
    endfunction

    // Downstream ready pattern.
    initial forever begin
        @(posedge clk);
        #1;
        case (rmode)
            0: dn_ready = 1'b1;
            1: dn_ready = !dn_ready;
            2: dn_ready = ($urandom_range(0, 1) == 1);
            default: dn_ready = 1'b0;
        endcase
    end

    // Output monitor: pops the scoreboard, tracks occupancy and done timing.
    initial forever begin
        logic [CW-1:0] e;
        logic          done_exp;
        @(negedge clk);
        cyc++;
        if (!rstn) begin
            occ_m    = 0;
            done_due = -1;
        end else begin
            done_exp = (cyc == done_due);
            if (done || done_exp) check("done_pulse", CW'(done), CW'(done_exp));
            if (done) done_cnt++;
            if (occ_m == 2) check("ready_when_full", CW'(up_ready), CW'(0));
            if (dn_valid && dn_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got %h expected none", {dn_flags, dn_data});
                end else begin
                    e = exp_q.pop_front();
                    check("beat", {dn_flags, dn_data}, e);
                    if (e[CW-1]) done_due = cyc + 1;
                end
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
                occ_m--;
            end
            if (up_valid && up_ready) occ_m++;
        end
    end

    task automatic run_cube(input int w, input int h, input int c, input int rm,
                            input bit gaps, input int bad, input bit chk_b2b);
        int            n;
        int            dc0;
        int            t;
        bit            acc;
        logic [DW-1:0] d;
        logic [3:0]    f;
        logic [13:0]   sb;
        n = (w + 1) * (h + 1) * (c / THROUGHPUT + 1);
        cw = 13'(w);
        ch = 13'(h);
        cc = 13'(c);
        rmode = rm;
        first_pop = -1;
        last_pop = -1;
        dc0 = done_cnt;
        @(posedge clk);
        #1 op_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("start_ready", CW'(up_ready), CW'(1));
        check("start_err", CW'(err), CW'(0));
        @(posedge clk);
        #1 op_en = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (gaps) begin
                up_valid = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            f = model_flags(k, w, h, c);
            d = {$urandom(), $urandom()};
            sb = 14'($urandom());
            sb[0] = f[1];
            sb[1] = f[2];
            sb[3] = f[3];
            if (k == bad) sb[0] = !sb[0];
            up_valid = 1'b1;
            up_pd = {sb, d};
            acc = 1'b0;
            t = 0;
            while (!acc && t < 200) begin
                @(negedge clk);
                if (up_ready) begin
                    acc = 1'b1;
                    exp_q.push_back({f, d});
                end
                @(posedge clk);
                #1;
                t++;
            end
            if (!acc) begin
                n_tests++;
                n_fail++;
                $display("FAIL accept_timeout: beat %0d not accepted, required acceptance", k);
                break;
            end
            if (k == bad) begin
                up_valid = 1'b0;
                @(negedge clk);
                check("err_set", CW'(err), CW'(1));
                @(posedge clk);
                #1;
            end
        end
        up_valid = 1'b0;
        t = 0;
        while (done_cnt == dc0 && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("done_count", CW'(done_cnt - dc0), CW'(1));
        check("end_err", CW'(err), CW'(bad >= 0));
        check("queue_empty", CW'(exp_q.size()), CW'(0));
        if (chk_b2b) check("back_to_back", CW'(last_pop - first_pop), CW'(n - 1));
    endtask

    task automatic reset_test();
        int            nacc;
        logic [DW-1:0] d;
        logic [3:0]    f;
        cw = 13'd3;
        ch = 13'd1;
        cc = 13'd7;
        rmode = 3;
        @(posedge clk);
        #1 op_en = 1'b1;
        @(posedge clk);
        #1 op_en = 1'b0;
        nacc = 0;
        up_valid = 1'b1;
        for (int t = 0; t < 20 && nacc < 2; t++) begin
            f = model_flags(nacc, 3, 1, 7);
            d = {$urandom(), $urandom()} | 64'd1;
            up_pd = {4'b0000, 6'd0, f[3], 1'b0, f[2], f[1], d};
            @(negedge clk);
            if (up_ready) begin
                nacc++;
                exp_q.push_back({f, d});
            end
            @(posedge clk);
            #1;
        end
        up_valid = 1'b0;
        check("fill_count", CW'(nacc), CW'(2));
        @(negedge clk);
        check("full_ready", CW'(up_ready), CW'(0));
        check("full_valid", CW'(dn_valid), CW'(1));
        @(posedge clk);
        #1 rstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_data", CW'(dn_data), CW'(0));
        check("midrst_ctl", CW'({up_ready, dn_valid, done, err, dn_flags}), CW'(0));
        @(posedge clk);
        #1 rstn = 1'b1;
        exp_q.delete();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_data", CW'(dn_data), CW'(0));
        check("rst_ctl", CW'({up_ready, dn_valid, done, err, dn_flags}), CW'(0));
        @(posedge clk);
        #1 rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        // Geometry, ready mode, upstream gaps, bad beat, back-to-back check.
        run_cube(3, 1, 7, 0, 1'b0, -1, 1'b1);
        run_cube(3, 1, 7, 1, 1'b1, -1, 1'b0);
        run_cube(0, 0, 0, 0, 1'b0, -1, 1'b0);
        run_cube(1, 0, 15, 2, 1'b1, -1, 1'b0);
        run_cube(3, 1, 7, 0, 1'b0, 2, 1'b0);
        run_cube(2, 2, 20, 2, 1'b1, -1, 1'b0);
        reset_test();
        run_cube(1, 1, 9, 2, 1'b1, -1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            run_cube(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 31)), 2, 1'b1, -1, 1'b0);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
